multi_clkdiv: RTL and testbench

//  Multi-channel, runtime-programmable clock/tick generator off the 100 MHz board clock.

---
 rtl/multi_clkdiv.sv | 122 ++++++++++++
 tb/tb_multi_clkdiv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clkdiv.sv
// Multi-channel programmable clock/tick divider; each channel runs its own divisor, enable and mode.
// All outputs registered (1-cycle latency from cfg_we); no backpressure, every config write is accepted and acked.
module multi_clkdiv #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 2000000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  output logic              cfg_ack,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  act_div_q  [NUM_CH];
  logic [CNT_W-1:0]  act_div_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_div_q [NUM_CH];
  logic [CNT_W-1:0]  pend_div_d [NUM_CH];
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              ack_q, ack_d;

  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    en_d       = en_q;
    mode_d     = mode_q;
    clk_d      = clk_q;
    tick_d     = tick_q;
    ack_d      = cfg_we;

    for (int i = 0; i < NUM_CH; i++) begin
      // Terminal processing sees pre-write state; a same-cycle write is layered on top below.
      if (en_q[i]) begin
        if (cnt_q[i] >= act_div_q[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          clk_d[i]  = ~clk_q[i] & ~mode_q[i];
          if (pend_vld_q[i]) begin
            act_div_d[i]  = pend_div_q[i];
            pend_vld_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
          tick_d[i] = 1'b0;
          clk_d[i]  = clk_q[i] & ~mode_q[i];
        end
      end else begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        clk_d[i]  = 1'b0;
      end

      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        en_d[i]   = cfg_en;
        mode_d[i] = cfg_mode;
        // A running channel defers the new divisor to its next period boundary to avoid runt periods.
        if (!en_q[i] || !cfg_en) begin
          act_div_d[i]  = cfg_div;
          pend_vld_d[i] = 1'b0;
        end else begin
          pend_div_d[i] = cfg_div;
          pend_vld_d[i] = 1'b1;
        end
        if (!cfg_en) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b0;
          clk_d[i]  = 1'b0;
        end
        if (cfg_mode) begin
          clk_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        act_div_q[i]  <= DIV_RST;
        pend_div_q[i] <= DIV_RST;
      end
      pend_vld_q <= '0;
      en_q       <= '1;
      mode_q     <= '0;
      clk_q      <= '0;
      tick_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign cfg_ack = ack_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_multi_clkdiv.sv
// Bench for multi_clkdiv: hand-derived vector table, corner sequences, and random config traffic
// checked against a timestamp-based model of each channel's tick schedule.
module tb_multi_clkdiv;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_mode = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_ack;
  logic [1:0] clk_out;
  logic [1:0] tick;

  logic       we2 = 1'b0;
  logic [1:0] ch2 = '0;
  logic [7:0] div2 = '0;
  logic       mode2 = 1'b0;
  logic       en2 = 1'b0;
  logic       ack2;
  logic [2:0] clk2;
  logic [2:0] tick2;

  multi_clkdiv #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3)) dut (
    .mclk(mclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .cfg_en(cfg_en), .cfg_ack(cfg_ack), .clk_out(clk_out), .tick(tick)
  );

  multi_clkdiv #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) dut3 (
    .mclk(mclk), .rst_n(rst_n), .cfg_we(we2), .cfg_ch(ch2), .cfg_div(div2),
    .cfg_mode(mode2), .cfg_en(en2), .cfg_ack(ack2), .clk_out(clk2), .tick(tick2)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;

  // Reference model: each enabled channel knows the absolute cycle of its next tick.
  int t;
  int m_nt [2];
  int m_dv [2];
  int m_pd [2];
  bit m_pv [2];
  bit m_en [2];
  bit m_mode [2];
  bit m_ck [2];
  bit m_tk [2];
  bit m_ack;

  task automatic model_reset();
    t = 0;
    m_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_dv[i] = 3; m_pd[i] = 3; m_pv[i] = 1'b0; m_en[i] = 1'b1;
      m_mode[i] = 1'b0; m_ck[i] = 1'b0; m_tk[i] = 1'b0;
      m_nt[i] = 3;
    end
  endtask

  task automatic model_step(input bit we, input int ch, input int div, input bit mo, input bit en);
    bit tk;
    bit ck;
    for (int i = 0; i < 2; i++) begin
      tk = 1'b0;
      ck = m_ck[i];
      if (m_en[i]) begin
        if (t == m_nt[i]) begin
          tk = 1'b1;
          ck = m_mode[i] ? 1'b0 : ~m_ck[i];
          if (m_pv[i]) begin
            m_dv[i] = m_pd[i];
            m_pv[i] = 1'b0;
          end
          m_nt[i] = t + m_dv[i] + 1;
        end else if (m_mode[i]) begin
          ck = 1'b0;
        end
      end else begin
        ck = 1'b0;
      end
      if (we && ch == i) begin
        if (!m_en[i] || !en) begin
          m_dv[i] = div;
          m_pv[i] = 1'b0;
        end else begin
          m_pd[i] = div;
          m_pv[i] = 1'b1;
        end
        if (!en) begin
          tk = 1'b0;
          ck = 1'b0;
        end else if (!m_en[i]) begin
          m_nt[i] = t + m_dv[i] + 1;
        end
        if (mo) ck = 1'b0;
        m_en[i] = en;
        m_mode[i] = mo;
      end
      m_tk[i] = tk;
      m_ck[i] = ck;
    end
    m_ack = we;
    t++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, t, got, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, {27'd0, cfg_ack, tick, clk_out},
        {27'd0, m_ack, m_tk[1], m_tk[0], m_ck[1], m_ck[0]});
  endtask

  task automatic drive(input bit we, input int ch, input int div, input bit mo, input bit en);
    cfg_we = we; cfg_ch = ch[0]; cfg_div = div[7:0]; cfg_mode = mo; cfg_en = en;
    @(posedge mclk);
    model_step(we, ch, div, mo, en);
    @(negedge mclk);
    cfg_we = 1'b0;
    we2 = 1'b0;
  endtask

  typedef struct {
    bit       we;
    int       ch;
    int       div;
    bit       mode;
    bit       en;
    bit       ack;
    bit [1:0] tk;
    bit [1:0] ck;
  } vec_t;

  function automatic vec_t v(bit we, int ch, int div, bit mo, bit en, bit ack, bit [1:0] tk, bit [1:0] ck);
    vec_t r;
    r.we = we; r.ch = ch; r.div = div; r.mode = mo; r.en = en;
    r.ack = ack; r.tk = tk; r.ck = ck;
    return r;
  endfunction

  vec_t tbl [17];

  initial begin
    int n;
    logic [2:0] exp_tk3;
    logic [2:0] exp_ck3;

    // Rows are per cycle after reset release; expected outputs follow the clock edge of that row.
    tbl[0]  = v(1, 0, 0, 1, 1,  1, 2'b00, 2'b00);
    tbl[1]  = v(0, 0, 0, 0, 0,  0, 2'b00, 2'b00);
    tbl[2]  = v(0, 0, 0, 0, 0,  0, 2'b00, 2'b00);
    tbl[3]  = v(0, 0, 0, 0, 0,  0, 2'b11, 2'b10);
    tbl[4]  = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b10);
    tbl[5]  = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b10);
    tbl[6]  = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b10);
    tbl[7]  = v(0, 0, 0, 0, 0,  0, 2'b11, 2'b00);
    tbl[8]  = v(1, 1, 2, 0, 0,  1, 2'b01, 2'b00);
    tbl[9]  = v(1, 1, 2, 0, 1,  1, 2'b01, 2'b00);
    tbl[10] = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b00);
    tbl[11] = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b00);
    tbl[12] = v(0, 0, 0, 0, 0,  0, 2'b11, 2'b10);
    tbl[13] = v(1, 0, 1, 0, 1,  1, 2'b01, 2'b10);
    tbl[14] = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b11);
    tbl[15] = v(0, 0, 0, 0, 0,  0, 2'b10, 2'b01);
    tbl[16] = v(0, 0, 0, 0, 0,  0, 2'b01, 2'b00);

    repeat (2) @(negedge mclk);
    chk("reset_state", {29'd0, cfg_ack, tick}, 32'd0);
    chk("reset_clk", {30'd0, clk_out}, 32'd0);
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      we2 = (i == 5); ch2 = 2'd3; div2 = 8'd0; mode2 = 1'b1; en2 = 1'b0;
      drive(tbl[i].we, tbl[i].ch, tbl[i].div, tbl[i].mode, tbl[i].en);
      chk($sformatf("table_row%0d", i), {29'd0, cfg_ack, tick, clk_out},
          {29'd0, tbl[i].ack, tbl[i].tk, tbl[i].ck});
      exp_tk3 = ((i % 4) == 3) ? 3'b111 : 3'b000;
      exp_ck3 = (((i + 1) / 4) % 2 == 1) ? 3'b111 : 3'b000;
      chk($sformatf("bad_ch_row%0d", i), {25'd0, ack2, tick2, clk2},
          {25'd0, (i == 5), exp_tk3, exp_ck3});
    end

    // Disable channel 0 mid-count, hold, then re-enable with divisor 5.
    drive(1, 0, 7, 0, 0);
    chk("disable_outputs", {30'd0, tick[0], clk_out[0]}, 32'd0);
    chk_model("disable_model");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("disabled_hold", {30'd0, tick[0], clk_out[0]}, 32'd0);
      chk_model("disabled_model");
    end
    drive(1, 0, 5, 0, 1);
    chk_model("reenable_model");
    n = 0;
    while (n < 20) begin
      drive(0, 0, 0, 0, 0);
      n++;
      chk_model("reenable_wait_model");
      if (tick[0]) break;
    end
    chk("first_tick_delay", n, 6);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 9),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      chk_model("random_a");
    end

    // Asynchronous reset asserted between clock edges.
    @(posedge mclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dut", {27'd0, cfg_ack, tick, clk_out}, 32'd0);
    chk("async_reset_dut3", {25'd0, ack2, tick2, clk2}, 32'd0);
    @(negedge mclk);
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 9),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      chk_model("random_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
